// File: rtl/rv_p4_rx_cell_packer_if.sv
// Beat-in / cell-out bus between a MAC RX lane, the cell packer and a switch RX port.
// master: the side that sources beats and accepts cells; slave: the packer.
interface rv_p4_rx_cell_packer_if;
  localparam int unsigned BEAT_W = 64;
  localparam int unsigned KEEP_W = 8;
  localparam int unsigned CELL_W = 512;
  localparam int unsigned LEN_W  = 7;

  logic              s_valid;
  logic              s_ready;
  logic [BEAT_W-1:0] s_data;
  logic [KEEP_W-1:0] s_keep;
  logic              s_last;
  logic              cell_valid;
  logic              cell_ready;
  logic              cell_sof;
  logic              cell_eof;
  logic [LEN_W-1:0]  cell_eop_len;
  logic [CELL_W-1:0] cell_data;

  modport master (
    output s_valid, s_data, s_keep, s_last, cell_ready,
    input  s_ready, cell_valid, cell_sof, cell_eof, cell_eop_len, cell_data
  );

  modport slave (
    input  s_valid, s_data, s_keep, s_last, cell_ready,
    output s_ready, cell_valid, cell_sof, cell_eof, cell_eop_len, cell_data
  );
endinterface

// File: rtl/rv_p4_rx_cell_packer.sv
// Per-port RX adapter: packs 8-byte MAC beats into 64-byte switch cells with
// sof/eof/eop_len, truncates frames reaching MAX_FRAME_BYTES and counts errors.
// Optional macro RV_P4_RX_RUNT_PAD_EN: single-cell frames under 60 bytes are
// reported as 60 bytes (the cell tail is already zero-filled).
module rv_p4_rx_cell_packer #(
  parameter int unsigned MAX_FRAME_BYTES = 9216,
  parameter int unsigned CNT_W           = 32
) (
  input  logic                  clk_mac,
  input  logic                  rst_n,
  rv_p4_rx_cell_packer_if.slave bus,
  output logic [CNT_W-1:0]      frame_cnt,
  output logic [CNT_W-1:0]      trunc_cnt,
  output logic [CNT_W-1:0]      proto_err_cnt
);
  localparam int unsigned BEAT_W     = 64;
  localparam int unsigned CELL_W     = 512;
  localparam int unsigned BEATS      = 8;
  localparam int unsigned FB_W       = 14;
  localparam int unsigned LEN_W      = 7;
  localparam int unsigned RUNT_BYTES = 60;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] MID  = 2'd1;
  localparam logic [1:0] DROP = 2'd2;

  logic [1:0]        state;
  logic [1:0]        state_next;
  logic [CELL_W-1:0] asm_buf;
  logic [2:0]        beat_idx;
  logic [FB_W-1:0]   frame_bytes;
  logic              sof_pend;

  logic              out_valid;
  logic              out_sof;
  logic              out_eof;
  logic [LEN_W-1:0]  out_len;
  logic [CELL_W-1:0] out_data;

  logic              s_ready_c;
  logic              accept_c;
  logic [3:0]        lead_c;
  logic [7:0]        lead_mask_c;
  logic [3:0]        nbytes_c;
  logic              keep_err_c;
  logic [BEAT_W-1:0] beat_c;
  logic [CELL_W-1:0] asm_c;
  logic [FB_W-1:0]   fb_next_c;
  logic              trunc_c;
  logic              complete_c;
  logic              sof_c;
  logic              eof_c;
  logic [LEN_W-1:0]  len_c;

  assign s_ready_c = rst_n && (!out_valid || bus.cell_ready);
  assign accept_c  = bus.s_valid && s_ready_c;

  assign bus.s_ready      = s_ready_c;
  assign bus.cell_valid   = out_valid;
  assign bus.cell_sof     = out_sof;
  assign bus.cell_eof     = out_eof;
  assign bus.cell_eop_len = out_len;
  assign bus.cell_data    = out_data;

  // Count contiguous enabled bytes starting at byte 0 (keep bit 7).
  always_comb begin
    logic run;
    lead_c = 4'd0;
    run    = 1'b1;
    for (int i = 7; i >= 0; i--) begin
      run = run & bus.s_keep[i];
      if (run) lead_c = lead_c + 4'd1;
    end
  end

  assign lead_mask_c = ~(8'hFF >> lead_c);
  // Non-last beats are always full; a last beat carries at least one byte.
  assign nbytes_c    = !bus.s_last ? 4'd8 : ((lead_c == 4'd0) ? 4'd1 : lead_c);
  assign keep_err_c  = bus.s_last ? ((lead_c == 4'd0) || (bus.s_keep != lead_mask_c))
                                  : (bus.s_keep != 8'hFF);

  // Zero the bytes past the valid count, then merge the beat at its cell slot.
  always_comb begin
    beat_c = '0;
    for (int i = 0; i < 8; i++) begin
      if (4'(i) < nbytes_c) beat_c[BEAT_W-1-8*i -: 8] = bus.s_data[BEAT_W-1-8*i -: 8];
    end
    asm_c = asm_buf;
    for (int b = 0; b < int'(BEATS); b++) begin
      if (beat_idx == 3'(b)) asm_c[CELL_W-1-BEAT_W*b -: BEAT_W] = beat_c;
    end
  end

  assign fb_next_c  = ((state == IDLE) ? FB_W'(0) : frame_bytes) + FB_W'(8);
  assign trunc_c    = accept_c && (state != DROP) && !bus.s_last &&
                      (fb_next_c == FB_W'(MAX_FRAME_BYTES));
  assign complete_c = accept_c && (state != DROP) &&
                      ((beat_idx == 3'd7) || bus.s_last || trunc_c);
  assign sof_c      = (state == IDLE) || sof_pend;
  assign eof_c      = bus.s_last || trunc_c;

  // Byte count of the closing cell; zero on non-eof cells.
  always_comb begin
    len_c = '0;
    if (eof_c) begin
      len_c = LEN_W'({beat_idx, 3'b000}) + LEN_W'(nbytes_c);
`ifdef RV_P4_RX_RUNT_PAD_EN
      if (sof_c && (len_c < LEN_W'(RUNT_BYTES))) len_c = LEN_W'(RUNT_BYTES);
`endif
    end
  end

  // Frame state register.
  always_ff @(posedge clk_mac) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Frame state transitions on accepted beats.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (accept_c && !bus.s_last) state_next = trunc_c ? DROP : MID;
      end
      MID: begin
        if (accept_c) begin
          if (bus.s_last)   state_next = IDLE;
          else if (trunc_c) state_next = DROP;
        end
      end
      DROP: begin
        if (accept_c && bus.s_last) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Assembly buffer, beat index and frame byte count.
  always_ff @(posedge clk_mac) begin
    if (!rst_n) begin
      asm_buf     <= '0;
      beat_idx    <= '0;
      frame_bytes <= '0;
      sof_pend    <= 1'b0;
    end else if (accept_c && (state != DROP)) begin
      frame_bytes <= fb_next_c;
      if (complete_c) begin
        asm_buf  <= '0;
        beat_idx <= '0;
        sof_pend <= 1'b0;
      end else begin
        asm_buf  <= asm_c;
        beat_idx <= beat_idx + 3'd1;
        sof_pend <= sof_c;
      end
    end
  end

  // Output cell register: load on completion, hold under backpressure.
  always_ff @(posedge clk_mac) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_sof   <= 1'b0;
      out_eof   <= 1'b0;
      out_len   <= '0;
      out_data  <= '0;
    end else if (complete_c) begin
      out_valid <= 1'b1;
      out_sof   <= sof_c;
      out_eof   <= eof_c;
      out_len   <= len_c;
      out_data  <= asm_c;
    end else if (bus.cell_ready) begin
      out_valid <= 1'b0;
    end
  end

  // Statistics counters, wrapping.
  always_ff @(posedge clk_mac) begin
    if (!rst_n) begin
      frame_cnt     <= '0;
      trunc_cnt     <= '0;
      proto_err_cnt <= '0;
    end else begin
      if (out_valid && bus.cell_ready && out_eof) frame_cnt <= frame_cnt + CNT_W'(1);
      if (trunc_c)                                trunc_cnt <= trunc_cnt + CNT_W'(1);
      if (accept_c && keep_err_c)                 proto_err_cnt <= proto_err_cnt + CNT_W'(1);
    end
  end
endmodule

// File: tb/tb_rv_p4_rx_cell_packer.sv
// Bench for rv_p4_rx_cell_packer: instance A (default size) and instance B
// (MAX_FRAME_BYTES=128) share stimulus; sel routes beats and cell_ready.
module tb_rv_p4_rx_cell_packer;
  typedef struct packed {
    logic         sof;
    logic         eof;
    logic [6:0]   len;
    logic [511:0] data;
  } cell_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        sel = 1'b0;
  logic        cr = 1'b1;
  logic        tx_valid = 1'b0;
  logic [63:0] tx_data = '0;
  logic [7:0]  tx_keep = '0;
  logic        tx_last = 1'b0;

  logic [31:0] a_frame, a_trunc, a_perr, b_frame, b_trunc, b_perr;
  logic        m_s_ready, m_cell_valid, m_cell_ready, m_sof, m_eof;
  logic [6:0]  m_len;
  logic [511:0] m_data;
  logic [31:0] m_frame, m_trunc, m_perr;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  cell_t exp_q[$];
  int pop_cyc[$];
  logic [7:0] fb[$];
  int exp_frame[2];
  int exp_trunc[2];
  int exp_perr[2];
  int stall_cnt;
  logic [7:0] ovr_keep0 = 8'hFF;
  logic [7:0] ovr_last = 8'h00;
  bit use_ovr_last = 0;
  bit drv_done;
  cell_t mon_e;
  logic [511:0] hold_data;

  rv_p4_rx_cell_packer_if ifa();
  rv_p4_rx_cell_packer_if ifb();

  assign ifa.s_valid = tx_valid && !sel;
  assign ifb.s_valid = tx_valid && sel;
  assign ifa.s_data = tx_data;
  assign ifb.s_data = tx_data;
  assign ifa.s_keep = tx_keep;
  assign ifb.s_keep = tx_keep;
  assign ifa.s_last = tx_last;
  assign ifb.s_last = tx_last;
  assign ifa.cell_ready = cr && !sel;
  assign ifb.cell_ready = cr && sel;

  assign m_s_ready    = sel ? ifb.s_ready : ifa.s_ready;
  assign m_cell_valid = sel ? ifb.cell_valid : ifa.cell_valid;
  assign m_cell_ready = sel ? ifb.cell_ready : ifa.cell_ready;
  assign m_sof        = sel ? ifb.cell_sof : ifa.cell_sof;
  assign m_eof        = sel ? ifb.cell_eof : ifa.cell_eof;
  assign m_len        = sel ? ifb.cell_eop_len : ifa.cell_eop_len;
  assign m_data       = sel ? ifb.cell_data : ifa.cell_data;
  assign m_frame      = sel ? b_frame : a_frame;
  assign m_trunc      = sel ? b_trunc : a_trunc;
  assign m_perr       = sel ? b_perr : a_perr;

  rv_p4_rx_cell_packer dut_a (
    .clk_mac(clk), .rst_n(rst_n), .bus(ifa),
    .frame_cnt(a_frame), .trunc_cnt(a_trunc), .proto_err_cnt(a_perr)
  );

  rv_p4_rx_cell_packer #(.MAX_FRAME_BYTES(128)) dut_b (
    .clk_mac(clk), .rst_n(rst_n), .bus(ifb),
    .frame_cnt(b_frame), .trunc_cnt(b_trunc), .proto_err_cnt(b_perr)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic gen_frame(input int n);
    fb.delete();
    for (int i = 0; i < n; i++) fb.push_back(8'($urandom_range(1, 255)));
  endtask

  // Reference model: split the effective frame bytes into expected cells.
  task automatic push_model(input int max_bytes);
    int n, used, ncell, cb;
    cell_t e;
    n = fb.size();
    used = (n > max_bytes) ? max_bytes : n;
    if (n > max_bytes) exp_trunc[sel]++;
    ncell = (used + 63) / 64;
    for (int c = 0; c < ncell; c++) begin
      cb = used - 64 * c;
      if (cb > 64) cb = 64;
      e.sof = (c == 0);
      e.eof = (c == ncell - 1);
      e.len = e.eof ? 7'(cb) : 7'd0;
      e.data = '0;
      for (int i = 0; i < cb; i++) e.data[511-8*i -: 8] = fb[64*c+i];
`ifdef RV_P4_RX_RUNT_PAD_EN
      if (e.sof && e.eof && cb < 60) e.len = 7'd60;
`endif
      exp_q.push_back(e);
    end
    exp_frame[sel]++;
  endtask

  // Drive fb as beats; unused bytes of the last beat carry filler.
  task automatic drive_fb(input int max_beats);
    int nb, cnt;
    bit ok, last;
    logic [63:0] d;
    logic [7:0] k;
    nb = (fb.size() + 7) / 8;
    stall_cnt = 0;
    for (int b = 0; b < nb && b < max_beats; b++) begin
      cnt = fb.size() - 8 * b;
      if (cnt > 8) cnt = 8;
      for (int i = 0; i < 8; i++) begin
        d[63-8*i -: 8] = (i < cnt) ? fb[8*b+i] : 8'hA5;
        k[7-i] = (i < cnt);
      end
      last = (b == nb - 1);
      if (b == 0 && !last) k = ovr_keep0;
      if (last && use_ovr_last) k = ovr_last;
      tx_valid = 1'b1;
      tx_data = d;
      tx_keep = k;
      tx_last = last;
      ok = 0;
      for (int t = 0; t < 200; t++) begin
        @(negedge clk);
        if (m_s_ready) begin
          ok = 1;
          break;
        end
        stall_cnt++;
      end
      if (!ok) begin
        tests++;
        fails++;
        $display("FAIL beat_accept_timeout beat %0d not accepted within 200 cycles", b);
      end
      @(posedge clk);
      #1;
    end
    tx_valid = 1'b0;
    tx_last = 1'b0;
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 1000) begin
      @(posedge clk);
      t++;
    end
    if (exp_q.size() != 0) begin
      tests++;
      fails++;
      $display("FAIL drain_timeout got %0d pending cells, required 0", exp_q.size());
      exp_q.delete();
    end
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    tests++; if (m_s_ready !== 1'b0) begin fails++; $display("FAIL reset_s_ready got %0b required 0", m_s_ready); end
    tests++; if (m_cell_valid !== 1'b0) begin fails++; $display("FAIL reset_cell_valid got %0b required 0", m_cell_valid); end
    tests++; if ({m_sof, m_eof, m_len} !== 9'd0) begin fails++; $display("FAIL reset_flags got %0h required 0", {m_sof, m_eof, m_len}); end
    tests++; if (m_data !== '0) begin fails++; $display("FAIL reset_cell_data got %0h required 0", m_data); end
    tests++; if ({m_frame, m_trunc, m_perr} !== 96'd0) begin fails++; $display("FAIL reset_counters got %0h required 0", {m_frame, m_trunc, m_perr}); end
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_cell_60();
    gen_frame(60);
    fb[0] = 8'hFF;
    push_model(9216);
    drive_fb(99);
    tests++; if (m_cell_valid !== 1'b1) begin fails++; $display("FAIL cell60_latency cell_valid got %0b required 1", m_cell_valid); end
    tests++; if (m_data[511:504] !== 8'hFF) begin fails++; $display("FAIL cell60_byte0 got %0h required ff", m_data[511:504]); end
    drain();
    tests++; if (m_frame !== 32'(exp_frame[0])) begin fails++; $display("FAIL cell60_frame_cnt got %0d required %0d", m_frame, exp_frame[0]); end
  endtask

  task automatic test_multi_cell_130();
    gen_frame(130);
    push_model(9216);
    drive_fb(99);
    drain();
    tests++; if (m_frame !== 32'(exp_frame[0])) begin fails++; $display("FAIL multi_frame_cnt got %0d required %0d", m_frame, exp_frame[0]); end
  endtask

  task automatic test_backpressure();
    int t;
    cr = 1'b0;
    gen_frame(130);
    push_model(9216);
    drv_done = 0;
    fork
      begin
        drive_fb(99);
        drv_done = 1;
      end
    join_none
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (!m_cell_valid && t < 200);
    tests++; if (m_cell_valid !== 1'b1) begin fails++; $display("FAIL bp_cell_wait got %0b required 1", m_cell_valid); end
    hold_data = m_data;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      tests++; if (m_s_ready !== 1'b0) begin fails++; $display("FAIL bp_s_ready cycle %0d got %0b required 0", i, m_s_ready); end
      tests++; if (m_data !== hold_data || m_cell_valid !== 1'b1) begin fails++; $display("FAIL bp_hold cycle %0d got valid %0b data %0h required valid 1 data %0h", i, m_cell_valid, m_data, hold_data); end
    end
    @(posedge clk);
    #1;
    cr = 1'b1;
    t = 0;
    while (!drv_done && t < 500) begin
      @(posedge clk);
      t++;
    end
    tests++; if (drv_done !== 1'b1) begin fails++; $display("FAIL bp_driver_done got %0b required 1", drv_done); end
    drain();
  endtask

  task automatic test_back_to_back();
    pop_cyc.delete();
    gen_frame(8);
    push_model(9216);
    drive_fb(99);
    gen_frame(8);
    push_model(9216);
    drive_fb(99);
    drain();
    tests++;
    if (pop_cyc.size() < 2) begin
      fails++;
      $display("FAIL b2b_pops got %0d required 2", pop_cyc.size());
    end else if (pop_cyc[pop_cyc.size()-1] - pop_cyc[pop_cyc.size()-2] != 1) begin
      fails++;
      $display("FAIL b2b_gap got %0d cycles required 1", pop_cyc[pop_cyc.size()-1] - pop_cyc[pop_cyc.size()-2]);
    end
  endtask

  task automatic test_keep_errors();
    gen_frame(9);
    ovr_keep0 = 8'h0F;
    use_ovr_last = 1;
    ovr_last = 8'hB0;
    push_model(9216);
    exp_perr[0] += 2;
    drive_fb(99);
    drain();
    tests++; if (m_perr !== 32'(exp_perr[0])) begin fails++; $display("FAIL keep_proto_err got %0d required %0d", m_perr, exp_perr[0]); end
    ovr_keep0 = 8'hFF;
    gen_frame(17);
    ovr_last = 8'h00;
    push_model(9216);
    exp_perr[0] += 1;
    drive_fb(99);
    drain();
    use_ovr_last = 0;
    tests++; if (m_perr !== 32'(exp_perr[0])) begin fails++; $display("FAIL keep_zero_proto_err got %0d required %0d", m_perr, exp_perr[0]); end
  endtask

  task automatic test_truncation();
    sel = 1'b1;
    #1;
    gen_frame(200);
    push_model(128);
    drive_fb(99);
    tests++; if (stall_cnt !== 0) begin fails++; $display("FAIL trunc_drop_stalls got %0d required 0", stall_cnt); end
    drain();
    tests++; if (m_trunc !== 32'(exp_trunc[1])) begin fails++; $display("FAIL trunc_cnt got %0d required %0d", m_trunc, exp_trunc[1]); end
    gen_frame(64);
    push_model(128);
    drive_fb(99);
    gen_frame(128);
    push_model(128);
    drive_fb(99);
    drain();
    tests++; if (m_trunc !== 32'(exp_trunc[1])) begin fails++; $display("FAIL trunc_exact_max got %0d required %0d", m_trunc, exp_trunc[1]); end
    tests++; if (m_frame !== 32'(exp_frame[1])) begin fails++; $display("FAIL trunc_frame_cnt got %0d required %0d", m_frame, exp_frame[1]); end
    sel = 1'b0;
    #1;
  endtask

  task automatic test_reset_mid_frame();
    gen_frame(64);
    drive_fb(3);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    tests++; if (m_s_ready !== 1'b0) begin fails++; $display("FAIL rstmid_s_ready got %0b required 0", m_s_ready); end
    @(posedge clk);
    #1;
    tests++; if ({m_cell_valid, m_sof, m_eof, m_len} !== 10'd0 || m_data !== '0) begin fails++; $display("FAIL rstmid_outputs got valid %0b data %0h required zero", m_cell_valid, m_data); end
    tests++; if ({a_frame, a_trunc, a_perr, b_frame, b_trunc, b_perr} !== 192'd0) begin fails++; $display("FAIL rstmid_counters got %0h required 0", {a_frame, a_perr, b_frame, b_trunc}); end
    for (int i = 0; i < 2; i++) begin
      exp_frame[i] = 0;
      exp_trunc[i] = 0;
      exp_perr[i] = 0;
    end
    rst_n = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    gen_frame(64);
    push_model(9216);
    drive_fb(99);
    drain();
    tests++; if (m_frame !== 32'(exp_frame[0])) begin fails++; $display("FAIL rstmid_frame_cnt got %0d required %0d", m_frame, exp_frame[0]); end
  endtask

  task automatic test_runt();
    gen_frame(20);
    push_model(9216);
    drive_fb(99);
    drain();
    tests++; if (m_frame !== 32'(exp_frame[0])) begin fails++; $display("FAIL runt_frame_cnt got %0d required %0d", m_frame, exp_frame[0]); end
  endtask

  initial begin
    for (int i = 0; i < 2; i++) begin
      exp_frame[i] = 0;
      exp_trunc[i] = 0;
      exp_perr[i] = 0;
    end
    // Scoreboard: compare each cell handed downstream against the model queue.
    fork
      forever begin
        @(negedge clk);
        if (rst_n && m_cell_valid && m_cell_ready) begin
          pop_cyc.push_back(cyc);
          if (exp_q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected_cell got sof %0b eof %0b len %0d required no cell", m_sof, m_eof, m_len);
          end else begin
            mon_e = exp_q.pop_front();
            tests++; if (m_sof !== mon_e.sof) begin fails++; $display("FAIL cell_sof got %0b required %0b", m_sof, mon_e.sof); end
            tests++; if (m_eof !== mon_e.eof) begin fails++; $display("FAIL cell_eof got %0b required %0b", m_eof, mon_e.eof); end
            tests++; if (m_len !== mon_e.len) begin fails++; $display("FAIL cell_eop_len got %0d required %0d", m_len, mon_e.len); end
            tests++; if (m_data !== mon_e.data) begin fails++; $display("FAIL cell_data got %0h required %0h", m_data, mon_e.data); end
          end
        end
      end
    join_none

    test_reset();
    test_cell_60();
    test_multi_cell_130();
    test_backpressure();
    test_back_to_back();
    test_keep_errors();
    test_truncation();
    test_reset_mid_frame();
    test_runt();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/rv_p4_rx_cell_packer.md
Name: rv_p4_rx_cell_packer

Overview:
- Per-port ingress adapter between one MAC RX lane and one switch RX port.
- Packs an 8-byte beat stream (data, keep, last) into 64-byte cells with sof, eof and eop_len.
- Drives the switch's per-port rx_valid/rx_sof/rx_eof/rx_eop_len/rx_data and honours rx_ready.
- Truncates oversize frames and counts protocol errors.
- One instance per port, in the clk_mac domain.

Parameters:
- MAX_FRAME_BYTES, 9216: largest accepted frame. Must be a multiple of 8 and at most 16383.
- CNT_W, 32: width of the statistics counters.

Ports:
- clk_mac  in  1  clock; all logic is on its rising edge
- rst_n  in  1  synchronous active-low reset
- s_valid  in  1  input beat valid
- s_ready  out  1  input beat accepted when s_valid && s_ready
- s_data  in  64  beat data; byte 0 of the beat is s_data[63:56]
- s_keep  in  8  byte enables; bit 7 = byte 0
- s_last  in  1  last beat of frame
- cell_valid  out  1  cell available
- cell_ready  in  1  downstream accepts the cell
- cell_sof  out  1  first cell of frame
- cell_eof  out  1  last cell of frame
- cell_eop_len  out  7  valid bytes in an eof cell (1..64); 0 on non-eof cells
- cell_data  out  512  cell data; byte 0 is [511:504]
- frame_cnt  out  CNT_W  frames emitted (eof cells accepted downstream)
- trunc_cnt  out  CNT_W  oversize frames truncated
- proto_err_cnt  out  CNT_W  malformed keep beats

Behaviour:
- Reset (rst_n=0 at a clk_mac edge):
  - Outputs: cell_valid=0, cell_sof=0, cell_eof=0, cell_eop_len=0, cell_data=0, all counters 0.
  - State: FSM to IDLE; assembly buffer, byte index and frame byte counter cleared.
  - Reset mid-frame discards the partial frame; no eof is emitted for it.
  - s_ready=0 while rst_n=0.
- s_ready = rst_n && (!cell_valid || cell_ready). Combinational from cell_ready; never depends on s_valid.
- Beat keep rules:
  - Non-last beat: must be 8'hFF. Any other value is treated as 8'hFF and proto_err_cnt is incremented.
  - Last beat: valid byte count = number of leading ones from bit 7. A non-contiguous keep counts leading ones only and increments proto_err_cnt.
  - Last beat with keep 8'h00: treated as 8'h80 (1 byte) and increments proto_err_cnt.
- Assembly:
  - An accepted beat fills the assembly buffer at byte offset 8*beat_idx. beat_idx is 0..7.
  - Unused bytes of a partial last cell are zero.
- Cell completion, on the accepting edge of the beat: beat_idx==7, or s_last, or truncation.
  - The assembled cell loads the output register and cell_valid=1 on the next cycle (1-cycle latency from the completing beat).
  - cell_sof=1 iff this is the first cell of the frame.
  - cell_eof=1 iff s_last or truncation.
  - cell_eop_len = bytes in the cell when eof (7'd64 for a full cell), else 0.
  - beat_idx resets to 0.
- Output register: holds its value while cell_valid && !cell_ready. It is cleared (cell_valid=0) when accepted with no new cell completing. A new cell may load in the same cycle the old one is accepted (back-to-back).
- FSM:
  - IDLE: next accepted beat is the frame start and goes to MID. If that beat has s_last, the single-cell frame completes and the FSM stays IDLE.
  - MID: on s_last, complete the frame and go to IDLE.
  - MID, oversize: a non-last beat that brings the frame byte count to exactly MAX_FRAME_BYTES closes the cell with eof=1 and increments trunc_cnt. Go to DROP.
  - DROP: s_ready follows the same rule. Accepted beats are discarded. On s_last, go to IDLE.
- A frame of exactly MAX_FRAME_BYTES ending with s_last is normal, not truncated.
- Counters wrap modulo 2^CNT_W.
- frame_cnt increments when cell_valid && cell_ready && cell_eof.

Optional Feature:
- Macro RV_P4_RX_RUNT_PAD_EN.
- Defined: a frame shorter than 60 bytes is zero-padded to 60 bytes. Its single cell reports cell_eop_len=60.
- Undefined: the true length is reported (1..59 allowed).
- Longer frames are unaffected in both cases.

Test Plan:
- 60-byte frame (7 beats of FF keep, 8th beat keep 8'hF0, s_last), cell_ready=1 -> one cell: sof=1, eof=1, eop_len=60, byte0=FF, byte59 matches input. Cell appears 1 cycle after the 8th beat. frame_cnt=1.
- 130-byte frame -> three cells: sof/eof/len = (1,0,0), (0,0,0), (0,1,2). Cell bytes match input order.
- cell_ready=0 held for 20 cycles with a cell pending -> s_ready=0. No beat lost. Cell data stable. After release, the next cell follows back-to-back.
- MAX_FRAME_BYTES=128, 200-byte frame -> two cells, second has eof=1, eop_len=64. Remaining 9 beats dropped with s_ready=1. trunc_cnt=1. The following 64-byte frame emits normally.
- Non-last beat keep 8'h0F, then last keep 8'hB0 -> proto_err_cnt=2. Last beat contributes 1 byte.
- Reset asserted after 3 beats of a frame -> no cell emitted. Outputs zero. A new 64-byte frame afterwards yields sof=1, eof=1, eop_len=64.
- With RV_P4_RX_RUNT_PAD_EN defined, a 20-byte frame -> eop_len=60, bytes 20..59 zero.
